// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock/tick divider.
package clk_div_pkg;

    localparam int CNT_WIDTH_DEF   = 32;
    localparam int DEFAULT_DIV_DEF = 5000;

    typedef logic [CNT_WIDTH_DEF-1:0] div_t;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } out_mode_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag and
// registered output. The shadow lands on a period boundary, sync, disable or idle.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  out_mode_t            i_mode,
    input  logic                 i_wr_hit,
    input  logic [CNT_WIDTH-1:0] i_wr_value,
    input  logic                 i_sync,
    output logic                 o_clk,
    output logic                 o_pending
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] shd_q, shd_d;
    logic                 pend_q, pend_d;
    logic                 out_q, out_d;

    logic [CNT_WIDTH-1:0] shd_eff_s;
    logic                 pend_eff_s;
    logic                 term_s;
    logic                 apply_s;

    // Next-state: a same-cycle write is folded in before deciding whether it lands now.
    always_comb begin
        shd_eff_s  = i_wr_hit ? i_wr_value : shd_q;
        pend_eff_s = i_wr_hit | pend_q;
        term_s     = (cnt_q == (div_q - CNT_WIDTH'(1)));
        cnt_d      = cnt_q;
        out_d      = out_q;
        apply_s    = 1'b0;
        if (i_sync || !i_enable || (div_q == '0)) begin
            cnt_d   = '0;
            out_d   = 1'b0;
            apply_s = 1'b1;
        end else if (term_s) begin
            cnt_d   = '0;
            out_d   = (i_mode == MODE_PULSE) ? 1'b1 : ~out_q;
            apply_s = 1'b1;
        end else begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            out_d   = (i_mode == MODE_PULSE) ? 1'b0 : out_q;
        end
        shd_d  = shd_eff_s;
        div_d  = (apply_s && pend_eff_s) ? shd_eff_s : div_q;
        pend_d = pend_eff_s && !apply_s;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= CNT_WIDTH'(DEFAULT_DIV);
            shd_q  <= CNT_WIDTH'(DEFAULT_DIV);
            pend_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            out_q  <= out_d;
        end
    end

    assign o_clk     = out_q;
    assign o_pending = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock/tick generator: decodes the divisor
// write strobe and instantiates one clk_div_channel per channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 i_clk_FPGA,
    input  logic                 i_reset,
    input  logic [CHANNELS-1:0]  i_enable,
    input  logic [CHANNELS-1:0]  i_mode,
    input  logic                 i_div_we,
    input  logic [SEL_W-1:0]     i_div_sel,
    input  logic [CNT_WIDTH-1:0] i_div_value,
    input  logic                 i_sync,
    output logic [CHANNELS-1:0]  o_clk,
    output logic [CHANNELS-1:0]  o_pending
);

    logic [CHANNELS-1:0] wr_hit_s;

    // Write decode; selects beyond the last channel match nothing.
    always_comb begin
        wr_hit_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit_s[i] = i_div_we && (i_div_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clk_div_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (i_clk_FPGA),
            .rst_n      (i_reset),
            .i_enable   (i_enable[g]),
            .i_mode     (out_mode_t'(i_mode[g])),
            .i_wr_hit   (wr_hit_s[g]),
            .i_wr_value (i_div_value),
            .i_sync     (i_sync),
            .o_clk      (o_clk[g]),
            .o_pending  (o_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (4 channels, default divisor 5000).
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en;
    logic [3:0]  mode;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] val;
    logic        sync;
    logic [3:0]  o_clk;
    logic [3:0]  o_pending;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(
        .CHANNELS    (4),
        .CNT_WIDTH   (32),
        .DEFAULT_DIV (5000)
    ) dut (
        .i_clk_FPGA  (clk),
        .i_reset     (rst_n),
        .i_enable    (en),
        .i_mode      (mode),
        .i_div_we    (we),
        .i_div_sel   (sel),
        .i_div_value (val),
        .i_sync      (sync),
        .o_clk       (o_clk),
        .o_pending   (o_pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] v);
        we  = 1'b1;
        sel = s;
        val = v;
        tick();
        we  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 4'hF;
        mode  = 4'h0;
        we    = 1'b0;
        sel   = 2'd0;
        val   = 32'd0;
        sync  = 1'b0;
        #12;
        check_eq("rst_clk", 32'(o_clk), 32'h0);
        check_eq("rst_pend", 32'(o_pending), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default divisor 5000 in toggle mode
        ticks(4999);
        check_eq("t1_e4999", 32'(o_clk[0]), 32'd0);
        tick();
        check_eq("t1_e5000", 32'(o_clk[0]), 32'd1);
        ticks(4999);
        check_eq("t1_e9999", 32'(o_clk[0]), 32'd1);
        tick();
        check_eq("t1_e10000", 32'(o_clk[0]), 32'd0);
        ticks(5000);
        check_eq("t1_e15000", 32'(o_clk[0]), 32'd1);

        // ch1: D=5, rewrite to 3 while C=2
        en[1] = 1'b0;
        tick();
        wr(2'd1, 32'd5);
        check_eq("t2_dis_wr_pend", 32'(o_pending[1]), 32'd0);
        en[1] = 1'b1;
        ticks(2);
        wr(2'd1, 32'd3);
        check_eq("t2_e3_pend", 32'(o_pending[1]), 32'd1);
        check_eq("t2_e3_clk", 32'(o_clk[1]), 32'd0);
        tick();
        check_eq("t2_e4_pend", 32'(o_pending[1]), 32'd1);
        tick();
        check_eq("t2_e5_clk", 32'(o_clk[1]), 32'd1);
        check_eq("t2_e5_pend", 32'(o_pending[1]), 32'd0);
        ticks(2);
        check_eq("t2_e7_clk", 32'(o_clk[1]), 32'd1);
        tick();
        check_eq("t2_e8_clk", 32'(o_clk[1]), 32'd0);
        ticks(2);
        check_eq("t2_e10_clk", 32'(o_clk[1]), 32'd0);
        tick();
        check_eq("t2_e11_clk", 32'(o_clk[1]), 32'd1);

        // ch2: pulse mode D=4, then D=1
        en[2] = 1'b0;
        tick();
        wr(2'd2, 32'd4);
        check_eq("t3_dis_wr_pend", 32'(o_pending[2]), 32'd0);
        mode[2] = 1'b1;
        en[2]   = 1'b1;
        ticks(3);
        check_eq("t3_e3", 32'(o_clk[2]), 32'd0);
        tick();
        check_eq("t3_e4", 32'(o_clk[2]), 32'd1);
        tick();
        check_eq("t3_e5", 32'(o_clk[2]), 32'd0);
        ticks(3);
        check_eq("t3_e8", 32'(o_clk[2]), 32'd1);
        wr(2'd2, 32'd1);
        check_eq("t3_e9_pend", 32'(o_pending[2]), 32'd1);
        check_eq("t3_e9_clk", 32'(o_clk[2]), 32'd0);
        ticks(3);
        check_eq("t3_e12_clk", 32'(o_clk[2]), 32'd1);
        check_eq("t3_e12_pend", 32'(o_pending[2]), 32'd0);
        for (int i = 13; i <= 15; i++) begin
            tick();
            check_eq($sformatf("t3_e%0d_const", i), 32'(o_clk[2]), 32'd1);
        end

        // ch3: idle at D=0, then D=2 lands immediately
        en[3] = 1'b0;
        tick();
        wr(2'd3, 32'd0);
        en[3] = 1'b1;
        ticks(3);
        check_eq("t4_idle_clk", 32'(o_clk[3]), 32'd0);
        check_eq("t4_idle_pend", 32'(o_pending[3]), 32'd0);
        wr(2'd3, 32'd2);
        check_eq("t4_wr_pend", 32'(o_pending[3]), 32'd0);
        check_eq("t4_wr_clk", 32'(o_clk[3]), 32'd0);
        tick();
        check_eq("t4_e1", 32'(o_clk[3]), 32'd0);
        tick();
        check_eq("t4_e2", 32'(o_clk[3]), 32'd1);
        tick();
        check_eq("t4_e3", 32'(o_clk[3]), 32'd1);
        tick();
        check_eq("t4_e4", 32'(o_clk[3]), 32'd0);

        // Sync with simultaneous write ch0=2; ch1 already at D=3
        sync = 1'b1;
        wr(2'd0, 32'd2);
        sync = 1'b0;
        check_eq("t5_sync_clk", 32'(o_clk[1:0]), 32'h0);
        check_eq("t5_sync_pend0", 32'(o_pending[0]), 32'd0);
        tick();
        check_eq("t5_e1", 32'(o_clk[1:0]), 32'h0);
        tick();
        check_eq("t5_e2", 32'(o_clk[1:0]), 32'h1);
        tick();
        check_eq("t5_e3", 32'(o_clk[1:0]), 32'h3);
        tick();
        check_eq("t5_e4", 32'(o_clk[1:0]), 32'h2);
        ticks(2);
        check_eq("t5_e6", 32'(o_clk[1:0]), 32'h1);

        // Async reset with a write pending on ch1
        wr(2'd1, 32'd7);
        check_eq("t6_pend_before", 32'(o_pending[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_clk", 32'(o_clk), 32'h0);
        check_eq("t6_rst_pend", 32'(o_pending), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(7);
        check_eq("t6_e7", 32'(o_clk[1]), 32'd0);
        ticks(4992);
        check_eq("t6_e4999", 32'(o_clk[1]), 32'd0);
        tick();
        check_eq("t6_e5000", 32'(o_clk[1]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
